// File: rtl/led_chaser_left_right.sv
// Single-LED chaser: one lit LED runs from MSB to LSB and wraps, stepping every STEP_DIV enabled clocks.
// Define LEDCHAY_BOUNCE_EN to build the ping-pong variant (adds a direction register).
module led_chaser_left_right #(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] OUT
);

    localparam int              CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] LEFT_LED  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] RIGHT_LED = WIDTH'(1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             step;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - RIGHT_LED)) == '0);
    endfunction

    always_comb begin
        div_cnt_d = div_cnt_q;
        step      = 1'b0;
        if (en) begin
            if (div_cnt_q == CNT_LAST) begin
                div_cnt_d = '0;
                step      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

`ifdef LEDCHAY_BOUNCE_EN
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    dir_e dir_q, dir_d, dir_eff;

    // End LEDs force the turn so each end is shown for exactly one step.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        dir_eff = dir_q;
        if (out_q == RIGHT_LED) begin
            dir_eff = DIR_LEFT;
        end else if (out_q == LEFT_LED) begin
            dir_eff = DIR_RIGHT;
        end
        if (step) begin
            if (!is_onehot(out_q)) begin
                out_d = LEFT_LED;
                dir_d = DIR_RIGHT;
            end else begin
                out_d = (dir_eff == DIR_LEFT) ? (out_q << 1) : (out_q >> 1);
                dir_d = dir_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= LEFT_LED;
            dir_q <= DIR_RIGHT;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end
`else
    // A corrupted (zero or multi-hot) pattern is replaced by the leftmost LED.
    always_comb begin
        out_d = out_q;
        if (step) begin
            if (!is_onehot(out_q) || (out_q == RIGHT_LED)) begin
                out_d = LEFT_LED;
            end else begin
                out_d = out_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= LEFT_LED;
        end else begin
            out_q <= out_d;
        end
    end
`endif

    assign OUT = out_q;

endmodule

// File: tb/tb_led_chaser_left_right.sv
// Bench for led_chaser_left_right: default instance and a STEP_DIV=4 instance against a position/phase model.
// Follows LEDCHAY_BOUNCE_EN the same way the design does.
module tb_led_chaser_left_right;

    localparam int W = 8;
`ifdef LEDCHAY_BOUNCE_EN
    localparam int PER = 2 * (W - 1);
`else
    localparam int PER = W;
`endif

    logic         clk;
    logic         reset;
    logic         en1, en4;
    logic [W-1:0] out1, out4;

    int total = 0;
    int bad   = 0;

    // Model: phase index into the LED sequence plus prescaler count.
    int ph1, cnt1, ph4, cnt4;

    led_chaser_left_right #(.WIDTH(W), .STEP_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .OUT(out1)
    );

    led_chaser_left_right #(.WIDTH(W), .STEP_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .OUT(out4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] led_of(input int ph);
        int pos;
        logic [W-1:0] one;
        one = W'(1);
`ifdef LEDCHAY_BOUNCE_EN
        pos = (ph < W) ? ph : (2 * (W - 1) - ph);
`else
        pos = ph;
`endif
        return one << (W - 1 - pos);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph1 = 0; cnt1 = 0;
        ph4 = 0; cnt4 = 0;
    endtask

    task automatic model_adv(input logic en, input int div, inout int ph, inout int cnt);
        if (en) begin
            if (cnt == div - 1) begin
                cnt = 0;
                ph  = (ph + 1) % PER;
            end else begin
                cnt++;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_adv(en1, 1, ph1, cnt1);
        model_adv(en4, 4, ph4, cnt4);
        @(negedge clk);
        check({tag, "_d1"}, out1, led_of(ph1));
        check({tag, "_d4"}, out4, led_of(ph4));
    endtask

    // Asynchronous pulse placed between edges; called just after a falling edge.
    task automatic pulse_reset(input string tag);
        #5 reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_async_d1"}, out1, 8'h80);
        check({tag, "_async_d4"}, out4, 8'h80);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en1   = 1'b0;
        en4   = 1'b0;
        model_reset();
        #1;
        check("reset_nolclk_d1", out1, 8'h80);
        check("reset_noclk_d4", out4, 8'h80);

        // Held through an edge while reset stays high.
        @(negedge clk);
        check("reset_hold_d1", out1, 8'h80);
        check("reset_hold_d4", out4, 8'h80);
        reset = 1'b0;
        en1   = 1'b1;
        en4   = 1'b1;

        // Run through a full sequence and wrap; first step on the first edge for dut1, fourth for dut4.
        tick("run1");
        check("first_step", out1, 8'h40);
        for (int i = 0; i < 7; i++) tick("run");
`ifndef LEDCHAY_BOUNCE_EN
        check("wrap_to_msb", out1, 8'h80);
`endif
        check("div4_edge8", out4, 8'h20);

        // Mid-run asynchronous reset, then the sequence restarts.
        pulse_reset("midrun");
        tick("after_rst");
        check("after_rst_step", out1, 8'h40);
        tick("after_rst");
        tick("after_rst");

        // Enable hold with dut1 showing 10.
        check("hold_setup", out1, 8'h10);
        en1 = 1'b0;
        for (int i = 0; i < 5; i++) tick("en_hold");
        check("en_hold_val", out1, 8'h10);
        en1 = 1'b1;
        tick("reenable");

        // Enable low from reset for 20 clocks; dut4 must then need four full edges.
        en1 = 1'b0;
        en4 = 1'b0;
        pulse_reset("idle");
        for (int i = 0; i < 20; i++) tick("idle");
        en1 = 1'b1;
        en4 = 1'b1;
        for (int i = 0; i < 3; i++) tick("idle_resume");
        check("div_cnt_kept_zero", out4, 8'h80);
        tick("idle_resume");
        check("div4_first_step", out4, 8'h40);

        // Prescaler gap: drop en for 3 cycles after the fifth edge.
        pulse_reset("gap");
        for (int i = 0; i < 5; i++) tick("gap_pre");
        en4 = 1'b0;
        for (int i = 0; i < 3; i++) tick("gap_off");
        en4 = 1'b1;
        for (int i = 0; i < 2; i++) tick("gap_on");
        check("gap_not_yet", out4, 8'h40);
        tick("gap_on");
        check("gap_step_delayed", out4, 8'h20);

        // Randomised enables with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            en1 = ($urandom_range(0, 3) != 0);
            en4 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) pulse_reset("rand");
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
